tsbus_arbiter: RTL and testbench

Round-robin arbiter and enable sequencer for a shared 4-bit tristate bus built from per-requester tristate drivers (`en ? a : 4'bz`). It grants the bus to one requester at a time and drives that requester's tristate `en` through a one-hot `gnt` vector. It inserts a one-cycle all-off turnaround between owners so two drivers never overlap. It sits between the bus masters' request lines and the `en` inputs of their tristate buffers.

---
 rtl/tsbus_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_tsbus_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tsbus_arbiter.sv
// -----------------------------------------------------------------------------
// tsbus_arbiter
//
// Round-robin arbiter and enable sequencer for a shared tristate bus built
// from per-requester drivers (en ? a : 'z). One requester owns the bus at a
// time. Every change of ownership, including a re-grant to the same
// requester, is separated by one cycle with all enables low. This keeps two
// drivers from ever overlapping.
//
// Parameters
//   N         number of requesters (2..8)
//   MAX_HOLD  maximum consecutive grant cycles before a forced handover
//             (1..255). Only used when TSBUS_HOLD_LIMIT_EN is defined.
//   IW        owner index width, must equal $clog2(N)
//
// Ports
//   clk    in   1    rising-edge clock
//   rst    in   1    asynchronous, active-high reset
//   req    in   N    request vector, bit i = requester i wants the bus
//   gnt    out  N    registered one-hot-or-zero enable vector for the drivers
//   owner  out  IW   registered index of the current or most recent owner
//   busy   out  1    registered, high exactly when gnt is nonzero
//
// Build option
//   TSBUS_HOLD_LIMIT_EN  when defined, an owner that has held the bus for
//                        MAX_HOLD cycles is forced through a turnaround if
//                        any other requester is waiting. When undefined, the
//                        hold counter is not built and an owner keeps the bus
//                        until it drops its request.
//
// States
//   state | meaning
//   IDLE  | bus undriven, arbitrating every cycle
//   GRANT | one driver enabled, owner holds while its req stays high
//   TURN  | one-cycle all-off gap after a release, arbitrating for next owner
// -----------------------------------------------------------------------------
module tsbus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IW       = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] owner,
  output logic          busy
);

  // Parameter legality is checked at elaboration. These branches produce no
  // hardware.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("tsbus_arbiter: N must be in 2..8");
  end
  if (IW != $clog2(N)) begin : g_bad_iw
    $error("tsbus_arbiter: IW must equal $clog2(N)");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("tsbus_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] owner_nxt;
  logic [N-1:0]  gnt_nxt;
  logic          busy_nxt;

  // Round-robin pick. The search starts one past the pointer and wraps
  // around, so the pointer position itself is checked last.
  logic          pick_found;
  logic [IW-1:0] pick_idx;

  function automatic logic [IW:0] rr_pick(input logic [N-1:0]  r,
                                          input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] idx;
    int            pos;
    found = 1'b0;
    idx   = ptr;
    for (int i = 1; i <= N; i++) begin
      pos = (int'(ptr) + i) % N;
      if (!found && r[pos]) begin
        found = 1'b1;
        idx   = IW'(pos);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    {pick_found, pick_idx} = rr_pick(req, last);
  end

  // Requests from everyone except the current owner. Used to decide whether
  // a forced handover has anyone to hand over to.
  logic [N-1:0] owner_oh;
  logic         owner_req;
  logic         others_req;

  always_comb begin
    owner_oh   = N'(1) << owner;
    owner_req  = |(req & owner_oh);
    others_req = |(req & ~owner_oh);
  end

`ifdef TSBUS_HOLD_LIMIT_EN
  logic [7:0] hcnt, hcnt_nxt;
  logic       hold_expired;

  always_comb begin
    hold_expired = (hcnt == 8'(MAX_HOLD)) && others_req;
  end
`else
  // Without the hold limit, competing requests never affect the owner.
  logic unused_others;
  always_comb begin
    unused_others = others_req;
  end
`endif

  // ---------------------------------------------------------------------------
  // State register. The outputs are registered here as well, so gnt, owner and
  // busy change only on a clock edge or on reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= IW'(N - 1);
      owner <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
`ifdef TSBUS_HOLD_LIMIT_EN
      hcnt  <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      owner <= owner_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
`ifdef TSBUS_HOLD_LIMIT_EN
      hcnt  <= hcnt_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    owner_nxt = owner;
`ifdef TSBUS_HOLD_LIMIT_EN
    hcnt_nxt  = hcnt;
`endif
    unique case (state)
      IDLE, TURN: begin
        if (pick_found) begin
          state_nxt = GRANT;
          owner_nxt = pick_idx;
          last_nxt  = pick_idx;
`ifdef TSBUS_HOLD_LIMIT_EN
          hcnt_nxt  = 8'd1;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_nxt = TURN;
`ifdef TSBUS_HOLD_LIMIT_EN
        end else if (hold_expired) begin
          state_nxt = TURN;
        end else if (hcnt != 8'd255) begin
          hcnt_nxt  = hcnt + 8'd1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. The decode uses the next state so the registered outputs
  // line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_nxt  = '0;
    busy_nxt = 1'b0;
    if (state_nxt == GRANT) begin
      gnt_nxt  = N'(1) << owner_nxt;
      busy_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_tsbus_arbiter.sv
module tb_tsbus_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] owner;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] gnt;
    int           owner;   // -1 = owner not checked
    string        tag;
  } exp_t;

  exp_t sb[$];

  tsbus_arbiter #(.N(N), .MAX_HOLD(8), .IW(IW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of req, push the hand-derived expectation, then pop and
  // compare it just after the edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] eg,
                      input int eo, input string tag);
    exp_t e;
    req = r;
    sb.push_back('{gnt: eg, owner: eo, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "_gnt"},  8'(gnt),  8'(e.gnt));
    chk({e.tag, "_busy"}, 8'(busy), 8'(e.gnt != '0));
    if (e.owner >= 0) chk({e.tag, "_owner"}, 8'(owner), 8'(e.owner));
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    #2;
    chk("rst_gnt",   8'(gnt),   8'h0);
    chk("rst_owner", 8'(owner), 8'h0);
    chk("rst_busy",  8'(busy),  8'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Every-cycle invariants, sampled away from the active edge.
  logic [N-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_onehot", 8'($onehot0(gnt)), 8'h1);
      chk("inv_busy",   8'(busy),           8'(|gnt));
      if (prev_gnt != '0 && gnt != '0)
        chk("inv_gap", 8'(gnt), 8'(prev_gnt));
      prev_gnt <= gnt;
    end else begin
      prev_gnt <= '0;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Basic grant / release
    do_reset();
    step(4'b0001, 4'b0001, 0,  "t1_grant");
    step(4'b0000, 4'b0000, -1, "t1_release");
    step(4'b0000, 4'b0000, -1, "t1_idle");
    step(4'b0000, 4'b0000, -1, "t1_idle2");

    // Rotation with one all-off cycle between owners
    do_reset();
    step(4'b1111, 4'b0001, 0,  "t2_g0a");
    step(4'b1111, 4'b0001, 0,  "t2_g0b");
    step(4'b1110, 4'b0000, -1, "t2_turn0");
    step(4'b1111, 4'b0010, 1,  "t2_g1a");
    step(4'b1111, 4'b0010, 1,  "t2_g1b");
    step(4'b1101, 4'b0000, -1, "t2_turn1");
    step(4'b1111, 4'b0100, 2,  "t2_g2a");
    step(4'b1111, 4'b0100, 2,  "t2_g2b");
    step(4'b1011, 4'b0000, -1, "t2_turn2");
    step(4'b1111, 4'b1000, 3,  "t2_g3a");
    step(4'b1111, 4'b1000, 3,  "t2_g3b");
    step(4'b0111, 4'b0000, -1, "t2_turn3");
    step(4'b1111, 4'b0001, 0,  "t2_g0c");
    step(4'b0000, 4'b0000, -1, "t2_end");
    step(4'b0000, 4'b0000, -1, "t2_idle");

    // Owner 2 releases with 0 and 3 waiting: 3 wins
    do_reset();
    step(4'b0100, 4'b0100, 2,  "t3_g2");
    step(4'b1101, 4'b0100, 2,  "t3_hold2");
    step(4'b1001, 4'b0000, -1, "t3_turn");
    step(4'b1001, 4'b1000, 3,  "t3_g3");
    step(4'b0000, 4'b0000, -1, "t3_rel");
    step(4'b0000, 4'b0000, -1, "t3_idle");

    // Hold limit behaviour
    do_reset();
`ifdef TSBUS_HOLD_LIMIT_EN
    for (int i = 0; i < 8; i++) step(4'b0011, 4'b0001, 0, "t4_hold0");
    step(4'b0011, 4'b0000, -1, "t4_turn0");
    for (int i = 0; i < 8; i++) step(4'b0011, 4'b0010, 1, "t4_hold1");
    step(4'b0011, 4'b0000, -1, "t4_turn1");
    step(4'b0011, 4'b0001, 0,  "t4_back0");
`else
    for (int i = 0; i < 20; i++) step(4'b0011, 4'b0001, 0, "t4_hold0");
`endif
    step(4'b0000, 4'b0000, -1, "t4_rel");
    step(4'b0000, 4'b0000, -1, "t4_idle");

    // Async reset mid-grant, then pointer restarts from N-1
    do_reset();
    step(4'b0100, 4'b0100, 2, "t5_g2");
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_gnt",  8'(gnt),  8'h0);
    chk("t5_async_busy", 8'(busy), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0110, 4'b0010, 1,  "t5_ptr");
    step(4'b0000, 4'b0000, -1, "t5_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
